// File: rtl/vga_game_pkg.sv
// Shared VGA game definitions: death overlay FSM states, RGB332 colours,
// and screen geometry.
package vga_game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        FADE  = 2'd2,
        HOLD  = 2'd3
    } death_state_t;

    localparam logic [7:0]  BLACK             = 8'h00;
    localparam logic [7:0]  FLASH_RGB_DEFAULT = 8'hE0;

    localparam int unsigned SCREEN_W_DEFAULT  = 640;
    localparam int unsigned SCREEN_H_DEFAULT  = 480;

    // Fade level at which the screen is fully covered
    localparam logic [4:0]  LEVEL_MAX         = 5'd16;

endpackage

// File: rtl/death_bayer4x4.sv
// 4x4 ordered-dither (Bayer) threshold lookup, purely combinational.
module death_bayer4x4 (
    input  logic [1:0] x,
    input  logic [1:0] y,
    output logic [3:0] threshold
);

    // Table lookup indexed by {row, column}
    always_comb begin
        threshold = 4'd0;
        case ({y, x})
            4'b00_00: threshold = 4'd0;
            4'b00_01: threshold = 4'd8;
            4'b00_10: threshold = 4'd2;
            4'b00_11: threshold = 4'd10;
            4'b01_00: threshold = 4'd12;
            4'b01_01: threshold = 4'd4;
            4'b01_10: threshold = 4'd14;
            4'b01_11: threshold = 4'd6;
            4'b10_00: threshold = 4'd3;
            4'b10_01: threshold = 4'd11;
            4'b10_10: threshold = 4'd1;
            4'b10_11: threshold = 4'd9;
            4'b11_00: threshold = 4'd15;
            4'b11_01: threshold = 4'd7;
            4'b11_10: threshold = 4'd13;
            4'b11_11: threshold = 4'd5;
            default:  threshold = 4'd0;
        endcase
    end

endmodule

// File: rtl/death_overlay_fader.sv
// Player-death screen overlay: flashes, dithers to black over 16 levels,
// then holds black until a restart is requested.
module death_overlay_fader
    import vga_game_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 16,
    parameter int unsigned FADE_STEP    = 4,
    parameter logic [7:0]  FLASH_RGB    = FLASH_RGB_DEFAULT,
    parameter int unsigned SCREEN_W     = SCREEN_W_DEFAULT,
    parameter int unsigned SCREEN_H     = SCREEN_H_DEFAULT
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        deathEvent,
    input  logic        restartReq,
    output logic        deathForeground_dr,
    output logic [7:0]  deathForegroundRGB,
    output logic        deathActive,
    output logic        gameOverDone
);

    localparam logic [5:0] FLASH_LAST = 6'(FLASH_FRAMES - 1);
    localparam logic [5:0] FADE_LAST  = 6'(FADE_STEP - 1);

    death_state_t r_state;
    death_state_t w_state_next;
    logic [5:0]   r_frameCnt;
    logic [5:0]   w_frameCnt_next;
    logic [4:0]   r_level;
    logic [4:0]   w_level_next;

    logic [3:0]   w_threshold;
    logic         w_inScreen;
    logic         w_draw;
    logic [7:0]   w_rgb;

    logic         r_dr;
    logic [7:0]   r_rgb;
    logic         r_gameOverDone;

    death_bayer4x4 u_bayer (
        .x         (pixelX[1:0]),
        .y         (pixelY[1:0]),
        .threshold (w_threshold)
    );

    assign w_inScreen = (32'(pixelX) < SCREEN_W) && (32'(pixelY) < SCREEN_H);

    // State and counter registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= IDLE;
            r_frameCnt <= '0;
            r_level    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_frameCnt <= w_frameCnt_next;
            r_level    <= w_level_next;
        end
    end

    // Next-state and counter update; frameCnt clears on every state change
    always_comb begin
        w_state_next    = r_state;
        w_frameCnt_next = r_frameCnt;
        w_level_next    = r_level;
        case (r_state)
            IDLE: begin
                if (deathEvent) begin
                    w_state_next    = FLASH;
                    w_frameCnt_next = '0;
                    w_level_next    = '0;
                end
            end
            FLASH: begin
                if (startOfFrame) begin
                    if (r_frameCnt == FLASH_LAST) begin
                        w_state_next    = FADE;
                        w_frameCnt_next = '0;
                        w_level_next    = 5'd1;
                    end else begin
                        w_frameCnt_next = r_frameCnt + 6'd1;
                    end
                end
            end
            FADE: begin
                if (startOfFrame) begin
                    if (r_frameCnt == FADE_LAST) begin
                        w_frameCnt_next = '0;
                        if (r_level < LEVEL_MAX) begin
                            w_level_next = r_level + 5'd1;
                        end else begin
                            w_state_next = HOLD;
                        end
                    end else begin
                        w_frameCnt_next = r_frameCnt + 6'd1;
                    end
                end
            end
            HOLD: begin
                if (restartReq) begin
                    w_state_next    = IDLE;
                    w_frameCnt_next = '0;
                    w_level_next    = '0;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_frameCnt_next = '0;
                w_level_next    = '0;
            end
        endcase
    end

    // Per-pixel overlay decision for the current state
    always_comb begin
        w_draw = 1'b0;
        w_rgb  = BLACK;
        case (r_state)
            FLASH: begin
                if (!r_frameCnt[2]) begin
                    w_draw = 1'b1;
                    w_rgb  = FLASH_RGB;
                end
            end
            FADE: begin
                if ({1'b0, w_threshold} < r_level) begin
                    w_draw = 1'b1;
                end
            end
            HOLD: begin
                w_draw = 1'b1;
            end
            default: begin
                w_draw = 1'b0;
            end
        endcase
    end

    // Output register stage aligned with the object mux; done pulses on HOLD entry
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_dr           <= 1'b0;
            r_rgb          <= BLACK;
            r_gameOverDone <= 1'b0;
        end else begin
            r_dr           <= w_draw && w_inScreen;
            r_rgb          <= (w_draw && w_inScreen) ? w_rgb : BLACK;
            r_gameOverDone <= (w_state_next == HOLD) && (r_state != HOLD);
        end
    end

    assign deathForeground_dr = r_dr;
    assign deathForegroundRGB = r_rgb;
    assign gameOverDone       = r_gameOverDone;
    assign deathActive        = (r_state != IDLE);

endmodule
